// File: rtl/synth_pkg.sv
// Shared definitions for the PDM receive path: CIC sizing, unipolar offset, decimator FSM states.
package synth_pkg;

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} dec_state_e;

    // Bit growth of an N-stage CIC at ratio 2^decim_log2, plus the input bit
    function automatic int cic_reg_bits(input int order, input int decim_log2);
        return order * decim_log2 + 1;
    endfunction

    // Unipolar input centres on half of full-scale CIC gain, i.e. 2^(reg_bits-2)
    function automatic longint unsigned unipolar_offset(input int reg_bits);
        return 64'd1 << (reg_bits - 2);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: diff = sample - sample captured at the previous enabled edge.
module cic_comb_stage #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] diff
);

    logic [WIDTH-1:0] delay;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            delay <= '0;
        else if (en)
            delay <= sample;
    end

    // Modular subtraction undoes integrator wrap-around
    assign diff = sample - delay;

endmodule

// File: rtl/pdm_decimator.sv
// PDM to PCM: CIC integrate/decimate/comb, offset removal, positive clamp, one-cycle strobe.
module pdm_decimator
    import synth_pkg::*;
#(
    parameter int OUTPUT_BITS = 12,
    parameter int CIC_ORDER   = 3,
    parameter int DECIM_LOG2  = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pdm_in,
    input  logic                   pdm_en,
    output logic [OUTPUT_BITS-1:0] pcm_out,
    output logic                   pcm_valid
);

    localparam int REG_BITS = cic_reg_bits(CIC_ORDER, DECIM_LOG2);
    localparam int WARM_W   = $clog2(CIC_ORDER + 1);
    localparam logic [REG_BITS-1:0] OFFSET  = REG_BITS'(unipolar_offset(REG_BITS));
    localparam logic [REG_BITS-1:0] SAT_POS = REG_BITS'(unipolar_offset(REG_BITS) - 1);

    logic [CIC_ORDER-1:0][REG_BITS-1:0] integ;
    logic [REG_BITS-1:0]                comb [CIC_ORDER+1];
    logic [DECIM_LOG2-1:0]              bit_cnt;
    logic                               tick_d;
    logic [WARM_W-1:0]                  warm_cnt;
    dec_state_e                         state;
    logic [REG_BITS-1:0]                d_raw;
    logic [REG_BITS-1:0]                d_sat;
    logic                               unused_low;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            integ <= '0;
        end else if (pdm_en) begin
            integ[0] <= integ[0] + REG_BITS'(pdm_in);
            for (int k = 1; k < CIC_ORDER; k++)
                integ[k] <= integ[k] + integ[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            tick_d  <= 1'b0;
        end else begin
            tick_d <= pdm_en && (bit_cnt == '1);
            if (pdm_en)
                bit_cnt <= bit_cnt + DECIM_LOG2'(1);
        end
    end

    assign comb[0] = integ[CIC_ORDER-1];

    for (genvar g = 0; g < CIC_ORDER; g++) begin : g_comb
        cic_comb_stage #(.WIDTH(REG_BITS)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .en     (tick_d),
            .sample (comb[g]),
            .diff   (comb[g+1])
        );
    end

    // Full-scale ones land exactly on +OFFSET, one LSB past the signed range
    always_comb begin
        d_raw = comb[CIC_ORDER] - OFFSET;
        d_sat = (d_raw == OFFSET) ? SAT_POS : d_raw;
    end

    assign unused_low = ^d_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            warm_cnt  <= '0;
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
        end else begin
            pcm_valid <= 1'b0;
            if (tick_d) begin
                case (state)
                    FILL: begin
                        if (warm_cnt == WARM_W'(CIC_ORDER - 1))
                            state <= RUN;
                        else
                            warm_cnt <= warm_cnt + WARM_W'(1);
                    end
                    RUN: begin
                        pcm_out   <= d_sat[REG_BITS-2 -: OUTPUT_BITS];
                        pcm_valid <= 1'b1;
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pdm_decimator.sv
// Bench for pdm_decimator: expected samples queued as bits are fed, checked as strobes arrive.
module tb_pdm_decimator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pdm_in = 1'b0;
    logic        pdm_en = 1'b0;
    logic [11:0] pcm_out;
    logic        pcm_valid;

    typedef struct {
        logic [11:0] value;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   cap_q[$];
    bit   capture = 1'b0;
    bit   gap_skip = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_strobe = 0;
    int   n_acc = 0;
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pdm_decimator dut (
        .clk       (clk),
        .rst       (rst),
        .pdm_in    (pdm_in),
        .pdm_en    (pdm_en),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid)
    );

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && pcm_valid) begin
            if (capture) begin
                cap_q.push_back(int'($signed(pcm_out)));
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got strobe pcm_out=%h at cycle %0d, required none", pcm_out, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (pcm_out !== mon_e.value) begin
                    errors++;
                    $display("FAIL sample_value: got %h required %h", pcm_out, mon_e.value);
                end
                if (mon_e.gap != 0) begin
                    checks++;
                    if (cyc - last_strobe != mon_e.gap) begin
                        errors++;
                        $display("FAIL strobe_gap: got %0d required %0d", cyc - last_strobe, mon_e.gap);
                    end
                end
            end
            last_strobe = cyc;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic b, input logic en);
        @(negedge clk);
        pdm_in = b;
        pdm_en = en;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        pdm_en = 1'b0;
        pdm_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_acc = 0;
        exp_q.delete();
    endtask

    // Feed one accepted bit; a sample is owed once the 4th and later windows complete
    task automatic feed_bit(input logic b, input logic [11:0] v, input int gap);
        exp_t e;
        step(b, 1'b1);
        n_acc++;
        if (n_acc % 64 == 0 && n_acc / 64 >= 4) begin
            e.value = v;
            e.gap = (n_acc / 64 == 4 || gap_skip) ? 0 : gap;
            gap_skip = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        pdm_en = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d samples outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pcm_out !== 12'h000 || pcm_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got pcm_out=%h valid=%b required 000/0", pcm_out, pcm_valid);
        end
        apply_reset();
        repeat (5) step(1'b1, 1'b1);
        checks++;
        if (pcm_out !== 12'h000 || pcm_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got pcm_out=%h valid=%b required 000/0", pcm_out, pcm_valid);
        end
    endtask

    task automatic test_ones();
        apply_reset();
        for (int i = 0; i < 64 * 40; i++) feed_bit(1'b1, 12'h7FF, 64);
        drain("ones");
    endtask

    task automatic test_zeros();
        apply_reset();
        for (int i = 0; i < 64 * 12; i++) feed_bit(1'b0, 12'h800, 64);
        drain("zeros");
    endtask

    task automatic test_alternating();
        apply_reset();
        for (int i = 0; i < 64 * 12; i++) feed_bit(((i % 2) == 0) ? 1'b1 : 1'b0, 12'h000, 64);
        drain("alternating");
    endtask

    task automatic test_sparse_enable();
        apply_reset();
        for (int i = 0; i < 64 * 7; i++) begin
            feed_bit(1'b1, 12'h7FF, 256);
            repeat (3) step(1'b1, 1'b0);
        end
        repeat (1000) step(1'b1, 1'b0);
        checks++;
        if (pcm_out !== 12'h7FF) begin
            errors++;
            $display("FAIL gap_hold: got %h required 7FF", pcm_out);
        end
        gap_skip = 1'b1;
        for (int i = 0; i < 64 * 2; i++) begin
            feed_bit(1'b1, 12'h7FF, 256);
            repeat (3) step(1'b1, 1'b0);
        end
        drain("sparse");
    endtask

    task automatic test_reset_mid_run();
        bit found;
        apply_reset();
        for (int i = 0; i < 64 * 5; i++) feed_bit(1'b1, 12'h7FF, 64);
        drain("pre_reset");
        step(1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            if (pcm_valid) found = 1'b1;
        end
        checks++;
        if (!found || pcm_out !== 12'h7FF) begin
            errors++;
            $display("FAIL pre_reset_strobe: got found=%b pcm_out=%h required 1/7FF", found, pcm_out);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (pcm_out !== 12'h000 || pcm_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got pcm_out=%h valid=%b required 000/0", pcm_out, pcm_valid);
        end
        @(negedge clk);
        pdm_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_acc = 0;
        exp_q.delete();
        for (int i = 0; i < 64 * 5; i++) feed_bit(1'b1, 12'h7FF, 64);
        drain("post_reset");
    endtask

    // First-order sigma-delta DAC model drives the decimator
    task automatic test_loopback(input logic signed [11:0] din);
        logic [11:0] acc;
        logic [12:0] sum;
        int          total;
        apply_reset();
        acc = '0;
        cap_q.delete();
        capture = 1'b1;
        for (int i = 0; i < 64 * 68; i++) begin
            sum = {1'b0, acc} + {1'b0, din ^ 12'h800};
            acc = sum[11:0];
            step(sum[12], 1'b1);
        end
        @(negedge clk);
        pdm_en = 1'b0;
        repeat (4) @(negedge clk);
        capture = 1'b0;
        checks++;
        if (cap_q.size() < 64) begin
            errors++;
            $display("FAIL loopback_count: got %0d strobes required >= 64", cap_q.size());
        end else begin
            total = 0;
            for (int i = 0; i < 64; i++) total += cap_q[i];
            checks++;
            if (total < 64 * (int'(din) - 8) || total > 64 * (int'(din) + 8)) begin
                errors++;
                $display("FAIL loopback_mean: got %0d/64 required %0d +/- 8", total, int'(din));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_zeros();
        test_alternating();
        test_sparse_enable();
        test_reset_mid_run();
        test_loopback(12'sd1024);
        test_loopback(-12'sd512);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
